// File: rtl/bj_input_pkg.sv
// rtl/bj_input_pkg.sv - Scancodes, key/joystick indices and coin FSM type for bj_input_ctl
package bj_input_pkg;

  // 9-bit codes are {extended, scancode}
  localparam logic [8:0] SC_P1_UP     = 9'h175;
  localparam logic [8:0] SC_P1_DOWN   = 9'h172;
  localparam logic [8:0] SC_P1_LEFT   = 9'h16B;
  localparam logic [8:0] SC_P1_RIGHT  = 9'h174;
  localparam logic [8:0] SC_P1_JUMP_A = 9'h029;
  localparam logic [8:0] SC_P1_JUMP_B = 9'h014;
  localparam logic [8:0] SC_P1_JUMP_C = 9'h114;
  localparam logic [8:0] SC_START1_A  = 9'h005;
  localparam logic [8:0] SC_START1_B  = 9'h016;
  localparam logic [8:0] SC_START2_A  = 9'h006;
  localparam logic [8:0] SC_START2_B  = 9'h01E;
  localparam logic [8:0] SC_COIN1     = 9'h02E;
  localparam logic [8:0] SC_COIN2     = 9'h036;
  localparam logic [8:0] SC_P2_UP     = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN   = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT   = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT  = 9'h034;
  localparam logic [8:0] SC_P2_JUMP   = 9'h01C;
  localparam logic [8:0] SC_TEST      = 9'h02C;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_JUMP   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN   = 7;

  // Key-state slots; each player's five slots follow the {jump,right,left,down,up} ctl order
  localparam int KEY_P1_UP    = 0;
  localparam int KEY_P1_DOWN  = 1;
  localparam int KEY_P1_LEFT  = 2;
  localparam int KEY_P1_RIGHT = 3;
  localparam int KEY_P1_JUMP  = 4;
  localparam int KEY_P2_UP    = 5;
  localparam int KEY_P2_DOWN  = 6;
  localparam int KEY_P2_LEFT  = 7;
  localparam int KEY_P2_RIGHT = 8;
  localparam int KEY_P2_JUMP  = 9;
  localparam int KEY_START1   = 10;
  localparam int KEY_START2   = 11;
  localparam int KEY_COIN1    = 12;
  localparam int KEY_COIN2    = 13;
  localparam int KEY_TEST     = 14;
  localparam int NUM_KEYS     = 15;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, WAIT_REL} coin_state_e;

  function automatic logic [NUM_KEYS-1:0] key_decode(input logic [8:0] code);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_P1_UP:                               m[KEY_P1_UP]    = 1'b1;
      SC_P1_DOWN:                             m[KEY_P1_DOWN]  = 1'b1;
      SC_P1_LEFT:                             m[KEY_P1_LEFT]  = 1'b1;
      SC_P1_RIGHT:                            m[KEY_P1_RIGHT] = 1'b1;
      SC_P1_JUMP_A, SC_P1_JUMP_B, SC_P1_JUMP_C: m[KEY_P1_JUMP] = 1'b1;
      SC_START1_A, SC_START1_B:               m[KEY_START1]   = 1'b1;
      SC_START2_A, SC_START2_B:               m[KEY_START2]   = 1'b1;
      SC_COIN1:                               m[KEY_COIN1]    = 1'b1;
      SC_COIN2:                               m[KEY_COIN2]    = 1'b1;
      SC_P2_UP:                               m[KEY_P2_UP]    = 1'b1;
      SC_P2_DOWN:                             m[KEY_P2_DOWN]  = 1'b1;
      SC_P2_LEFT:                             m[KEY_P2_LEFT]  = 1'b1;
      SC_P2_RIGHT:                            m[KEY_P2_RIGHT] = 1'b1;
      SC_P2_JUMP:                             m[KEY_P2_JUMP]  = 1'b1;
      SC_TEST:                                m[KEY_TEST]     = 1'b1;
      default:                                m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] joy_dirs(input logic [4:0] j);
    return {j[JOY_JUMP], j[JOY_RIGHT], j[JOY_LEFT], j[JOY_DOWN], j[JOY_UP]};
  endfunction

  // Horizontal cabinet: up<-left, down<-right, left<-down, right<-up; jump untouched
  function automatic logic [4:0] rotate_dirs(input logic [4:0] c, input logic rot);
    return rot ? {c[4], c[0], c[1], c[3], c[2]} : c;
  endfunction

endpackage

// File: rtl/bj_coin_pulse.sv
// rtl/bj_coin_pulse.sv - One-shot coin pulse of COIN_FRAMES frames, COIN_GAP frame gap, no auto-repeat
module bj_coin_pulse #(
  parameter int COIN_FRAMES = 4,
  parameter int COIN_GAP    = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  input  logic frame_tick,
  output logic coin
);
  import bj_input_pkg::*;

  localparam logic [3:0] LP_FRAMES_LAST = 4'(COIN_FRAMES - 1);
  localparam logic [3:0] LP_GAP_LAST    = 4'(COIN_GAP - 1);
  localparam bit         LP_HAS_GAP     = (COIN_GAP != 0);

  coin_state_e r_state;
  coin_state_e w_state_nxt;
  logic        r_req_prev;
  logic        r_rise;
  logic [3:0]  r_frame_cnt;
  logic        w_frames_done;
  logic        w_gap_done;

  // r_req_prev resets high so a request held through reset release is not an edge
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_req_prev <= 1'b1;
      r_rise     <= 1'b0;
    end else begin
      r_req_prev <= req;
      r_rise     <= req & ~r_req_prev;
    end
  end

  assign w_frames_done = frame_tick && (r_frame_cnt == LP_FRAMES_LAST);
  assign w_gap_done    = frame_tick && (r_frame_cnt == LP_GAP_LAST);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_frame_cnt <= 4'd0;
    end else if (w_state_nxt != r_state) begin
      r_frame_cnt <= 4'd0;
    end else if (frame_tick && (r_state == ACTIVE || r_state == GAP)) begin
      r_frame_cnt <= r_frame_cnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_rise) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_frames_done) w_state_nxt = LP_HAS_GAP ? GAP : WAIT_REL;
      end
      GAP: begin
        if (w_gap_done) w_state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    coin = 1'b0;
    if (r_state == ACTIVE) coin = 1'b1;
  end

endmodule

// File: rtl/bj_input_ctl.sv
// rtl/bj_input_ctl.sv - Bomb Jack input stage: PS/2 key states, pad merge, rotate remap, coin shaping
module bj_input_ctl #(
  parameter int COIN_FRAMES = 4,
  parameter int COIN_GAP    = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [4:0]  p1_ctl,
  output logic [4:0]  p2_ctl,
  output logic        p1_start,
  output logic        p2_start,
  output logic        p1_coin,
  output logic        p2_coin,
  output logic        test
);
  import bj_input_pkg::*;

  logic                r_toggle;
  logic [NUM_KEYS-1:0] r_keys;
  logic                r_vblank_prev;
  logic [4:0]          r_p1_ctl;
  logic [4:0]          r_p2_ctl;
  logic                r_p1_start;
  logic                r_p2_start;
  logic                r_test;

  logic                w_event;
  logic [NUM_KEYS-1:0] w_key_mask;
  logic [4:0]          w_p1_merged;
  logic [4:0]          w_p2_merged;
  logic                w_start1;
  logic                w_start2;
  logic                w_coin1_req;
  logic                w_coin2_req;
  logic                w_frame_tick;
  logic [7:0]          w_unused_joy;

  assign w_event      = ps2_key[10] ^ r_toggle;
  assign w_key_mask   = key_decode(ps2_key[8:0]);
  assign w_unused_joy = joystick_0[15:8] ^ joystick_1[15:8];

  // Toggle copy tracks the input even in reset so release never looks like an event
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_toggle <= ps2_key[10];
      r_keys   <= '0;
    end else begin
      r_toggle <= ps2_key[10];
      if (w_event) begin
        r_keys <= (r_keys & ~w_key_mask) | (w_key_mask & {NUM_KEYS{ps2_key[9]}});
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_vblank_prev <= vblank;
    end else begin
      r_vblank_prev <= vblank;
    end
  end

  assign w_frame_tick = vblank & ~r_vblank_prev;

  assign w_p1_merged = r_keys[KEY_P1_JUMP:KEY_P1_UP] | joy_dirs(joystick_0[4:0]);
  assign w_p2_merged = r_keys[KEY_P2_JUMP:KEY_P2_UP] | joy_dirs(joystick_1[4:0]);
  assign w_start1    = r_keys[KEY_START1] | joystick_0[JOY_START1] | joystick_1[JOY_START1];
  assign w_start2    = r_keys[KEY_START2] | joystick_0[JOY_START2] | joystick_1[JOY_START2];
  assign w_coin1_req = r_keys[KEY_COIN1] | joystick_0[JOY_COIN];
  assign w_coin2_req = r_keys[KEY_COIN2] | joystick_1[JOY_COIN];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_p1_ctl   <= 5'd0;
      r_p2_ctl   <= 5'd0;
      r_p1_start <= 1'b0;
      r_p2_start <= 1'b0;
      r_test     <= 1'b0;
    end else begin
      r_p1_ctl   <= rotate_dirs(w_p1_merged, rotate);
      r_p2_ctl   <= rotate_dirs(w_p2_merged, rotate);
      r_p1_start <= w_start1;
      r_p2_start <= w_start2;
      r_test     <= r_keys[KEY_TEST];
    end
  end

  assign p1_ctl   = r_p1_ctl;
  assign p2_ctl   = r_p2_ctl;
  assign p1_start = r_p1_start;
  assign p2_start = r_p2_start;
  assign test     = r_test;

  bj_coin_pulse #(
    .COIN_FRAMES (COIN_FRAMES),
    .COIN_GAP    (COIN_GAP)
  ) u_coin1 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .req        (w_coin1_req),
    .frame_tick (w_frame_tick),
    .coin       (p1_coin)
  );

  bj_coin_pulse #(
    .COIN_FRAMES (COIN_FRAMES),
    .COIN_GAP    (COIN_GAP)
  ) u_coin2 (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .req        (w_coin2_req),
    .frame_tick (w_frame_tick),
    .coin       (p2_coin)
  );

endmodule

// File: tb/tb_bj_input_ctl.sv
// tb/tb_bj_input_ctl.sv - Scoreboard bench for bj_input_ctl
module tb_bj_input_ctl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        vblank;
  logic [4:0]  p1_ctl;
  logic [4:0]  p2_ctl;
  logic        p1_start;
  logic        p2_start;
  logic        p1_coin;
  logic        p2_coin;
  logic        test;

  // Observed vector: {p1_ctl, p2_ctl, p1_start, p2_start, p1_coin, p2_coin, test}
  typedef struct {
    int          cyc;
    logic [14:0] val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic        tog      = 1'b0;
  logic        sim_done = 1'b0;
  logic [14:0] out_vec;
  logic [14:0] last_vec = '0;

  bj_input_ctl #(
    .COIN_FRAMES (4),
    .COIN_GAP    (4)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .vblank     (vblank),
    .p1_ctl     (p1_ctl),
    .p2_ctl     (p2_ctl),
    .p1_start   (p1_start),
    .p2_start   (p2_start),
    .p1_coin    (p1_coin),
    .p2_coin    (p2_coin),
    .test       (test)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  assign out_vec = {p1_ctl, p2_ctl, p1_start, p2_start, p1_coin, p2_coin, test};

  // Monitor: pops every expectation due this cycle; any unannounced output change is an error
  always @(negedge clk_sys) begin
    exp_t e;
    logic hit;
    hit = 1'b0;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not evaluated (now %0d)", e.name, e.cyc, cyc);
      end else begin
        hit = 1'b1;
        if (out_vec !== e.val) begin
          failures++;
          $display("FAIL %s: cycle %0d got=%h expected=%h", e.name, cyc, out_vec, e.val);
        end
      end
    end
    if (!hit && out_vec !== last_vec) begin
      checks++;
      failures++;
      $display("FAIL unexpected_change: cycle %0d got=%h expected=%h", cyc, out_vec, last_vec);
    end
    last_vec = out_vec;
    if (sim_done) begin
      checks++;
      if (sb_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: pending=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic expect_at(input int dc, input logic [14:0] v, input string name);
    sb_q.push_back('{cyc + dc, v, name});
  endtask

  task automatic key(input logic pressed, input logic [8:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, code};
  endtask

  task automatic frame();
    vblank = 1'b1;
    step(2);
    vblank = 1'b0;
    step(3);
  endtask

  initial begin
    reset_n    = 1'b0;
    ps2_key    = 11'h000;
    joystick_0 = 16'h0000;
    joystick_1 = 16'h0080;
    rotate     = 1'b0;
    vblank     = 1'b0;
    step(3);
    expect_at(0, 15'h0000, "reset_outputs");
    step(1);

    // pad-2 coin held through reset release must not fire
    reset_n = 1'b1;
    step(6);
    expect_at(0, 15'h0000, "coin_held_through_reset");
    joystick_1 = 16'h0000;
    step(2);
    joystick_1 = 16'h0080;
    expect_at(2, 15'h0002, "p2_coin_rise");
    step(4);
    frame(); frame(); frame();
    expect_at(1, 15'h0000, "p2_coin_fall_after_4_frames");
    frame();
    joystick_1 = 16'h0000;
    step(2);

    key(1'b1, 9'h175);
    expect_at(2, 15'h0400, "key_up_press");
    step(4);
    key(1'b0, 9'h175);
    expect_at(2, 15'h0000, "key_up_release");
    step(4);

    rotate = 1'b1;
    joystick_0 = 16'h0002;
    expect_at(1, 15'h0400, "rotate_left_to_up");
    step(3);
    rotate = 1'b0;
    expect_at(1, 15'h1000, "norotate_left");
    step(3);
    joystick_0 = 16'h0000;
    expect_at(1, 15'h0000, "joy_clear");
    step(3);

    key(1'b1, 9'h01A);
    expect_at(3, 15'h0000, "unmapped_ignored");
    step(5);
    key(1'b1, 9'h114);
    expect_at(2, 15'h4000, "ext_jump_press");
    step(3);
    key(1'b0, 9'h114);
    expect_at(2, 15'h0000, "ext_jump_release");
    step(3);

    // back-to-back events on consecutive cycles
    key(1'b1, 9'h02C);
    expect_at(2, 15'h0001, "b2b_test_press");
    step(1);
    key(1'b1, 9'h005);
    expect_at(2, 15'h0011, "b2b_start1_press");
    step(1);
    key(1'b0, 9'h02C);
    expect_at(2, 15'h0010, "b2b_test_release");
    step(1);
    key(1'b0, 9'h005);
    expect_at(2, 15'h0000, "b2b_start1_release");
    step(4);

    rotate = 1'b1;
    key(1'b1, 9'h023);
    expect_at(2, 15'h0020, "p2_key_left_rotated_up");
    step(3);
    rotate = 1'b0;
    expect_at(1, 15'h0080, "p2_key_left_straight");
    step(3);
    joystick_1 = 16'h0041;
    expect_at(1, 15'h0188, "p2_pad_right_start2");
    step(3);
    joystick_1 = 16'h0000;
    key(1'b0, 9'h023);
    expect_at(1, 15'h0080, "p2_pad_release");
    expect_at(2, 15'h0000, "p2_key_release");
    step(4);
    joystick_0 = 16'h0040;
    expect_at(1, 15'h0008, "p1_pad_start2");
    step(3);
    joystick_0 = 16'h0000;
    expect_at(1, 15'h0000, "p1_pad_start2_release");
    step(3);

    // coin key held for 20 frames with up also held
    key(1'b1, 9'h175);
    expect_at(2, 15'h0400, "hold_up");
    step(3);
    key(1'b1, 9'h02E);
    expect_at(3, 15'h0404, "coin_key_rise");
    step(5);
    frame(); frame(); frame();
    expect_at(1, 15'h0400, "coin_key_fall_after_4_frames");
    frame();
    repeat (16) frame();
    key(1'b0, 9'h02E);
    step(4);
    key(1'b1, 9'h02E);
    expect_at(3, 15'h0404, "coin_repress");
    step(5);

    reset_n = 1'b0;
    expect_at(1, 15'h0000, "reset_mid_pulse");
    step(1);
    reset_n = 1'b1;
    step(6);
    expect_at(0, 15'h0000, "keys_cleared_after_reset");
    step(3);
    sim_done = 1'b1;
  end

endmodule

// File: doc/bj_input_ctl.md
# bj_input_ctl

Input conditioning stage for the Bomb Jack core. It sits between hps_io (PS/2 key events, joystick words) and the bombjack_top control inputs. It keeps a registered pressed-state per mapped key and merges it with the joystick bits. It applies the horizontal-orientation direction remap and shapes each coin request into a fixed-length, frame-timed pulse that cannot auto-repeat.

## Interface
Parameters:
- COIN_FRAMES, 4: vblank frames a coin output stays high (1..15)
- COIN_GAP, 4: vblank frames of forced low after a pulse before re-arm (0..15)

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset_n  in  1  synchronous, active-low reset
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scancode
- joystick_0  in  16  player-1 pad: [0] right [1] left [2] down [3] up [4] jump [5] start1 [6] start2 [7] coin
- joystick_1  in  16  player-2 pad, same bit layout
- rotate  in  1  1 = horizontal orientation, remap directions
- vblank  in  1  video vertical blank, clk_sys domain; rising edge = frame tick
- p1_ctl  out  5  {jump,right,left,down,up}, player 1
- p2_ctl  out  5  same, player 2
- p1_start, p2_start  out  1  start buttons
- p1_coin, p2_coin  out  1  shaped coin pulses
- test  out  1  service/test key

## Operation
- Key event: `ps2_key[10]` differs from its registered copy. The event is then decoded against the 9-bit code {[8],[7:0]}. A matching key state is written with `ps2_key[9]`. Unmapped codes are ignored.
- Key map:
  - Player 1 directions: 0x175 up, 0x172 down, 0x16B left, 0x174 right.
  - Player 1 jump: 0x029, 0x014, 0x114.
  - Starts: 0x005/0x016 start1, 0x006/0x01E start2.
  - Coins: 0x02E coin1, 0x036 coin2.
  - Player 2: 0x02D up, 0x02B down, 0x023 left, 0x034 right, 0x01C jump.
  - Service: 0x02C test.
- Merge:
  - p1 directions/jump = P1 key | joystick_0. p2 = P2 key | joystick_1. Pads are not cross-ORed.
  - start1 = keys | joystick_0[5] | joystick_1[5]. start2 likewise with bit [6].
  - coin1 req = key | joystick_0[7]. coin2 req = key | joystick_1[7].
- Rotate = 1, per player, after merge: up←left, down←right, left←down, right←up. Jump is unaffected. Rotate = 0 passes directions straight through.
- Opposing directions are passed through unfiltered.
- Coin shaper, one per slot, 4 states:
  - IDLE: rising edge of req → ACTIVE, frame counter cleared, output 1.
  - ACTIVE: count vblank ticks. At COIN_FRAMES → GAP (or WAIT_REL if COIN_GAP = 0), output 0.
  - GAP: at COIN_GAP ticks → WAIT_REL.
  - WAIT_REL: req low → IDLE. req still high stays here, so a held coin gives exactly one pulse.
- The req edge-detect register resets to 1, so a coin held through reset release does not fire.
- Reset values: all key states 0, all outputs 0, coin FSMs IDLE, frame counters 0. The toggle copy loads `ps2_key[10]`, so no spurious event fires on reset release.

## Timing
- Key event to output: 2 cycles (edge detect, then decoded state and merged output register).
- Joystick change to output: 1 cycle (registered merge).
- rotate change to output: 1 cycle. Key states are not altered by rotate.
- Coin: req rising at cycle N → coin output high at N+2, for exactly COIN_FRAMES vblank rising edges.
- Frame ticks: a vblank rising edge is one tick regardless of vblank high duration. A tick in the same cycle as entry to ACTIVE is not counted.
- Back-to-back key events on consecutive cycles are both applied in order.
- reset_n low mid-pulse forces the coin output to 0 in the next cycle.

## Structure
- Package bj_input_pkg holds:
  - the 9-bit scancode localparams
  - joystick bit-index localparams
  - coin FSM enum {IDLE, ACTIVE, GAP, WAIT_REL}
- Sub-module bj_coin_pulse (parameters COIN_FRAMES, COIN_GAP; inputs clk_sys, reset_n, req, frame_tick; output coin), instantiated twice.
- Vblank edge detection lives once in the top and is shared by both instances.

## Test plan
- Toggle `ps2_key[10]` with {pressed=1, code 0x175}, then pressed=0 → p1_ctl[0] rises 2 cycles after the first toggle and falls 2 cycles after the second.
- rotate=1, joystick_0=0x0002 (left) → p1_ctl=5'b00001 (up). rotate=0 → 5'b00100 (left), 1 cycle after the change.
- Coin key 0x02E held for 20 frames with COIN_FRAMES=4, COIN_GAP=4 → p1_coin high for exactly 4 vblank edges, then no second pulse until release and re-press.
- joystick_1[7] held across reset_n deassertion → p2_coin stays 0. Release then press → one pulse.
- Unmapped code 0x01A pressed → all outputs unchanged. 0x114 pressed → p1 jump=1.
- reset_n low for 1 cycle during ACTIVE → p1_coin=0 the next cycle, FSM in IDLE, key states cleared.
